// File: rtl/noc_local_inject_arbiter_pkg.sv
// noc_local_inject_arbiter_pkg: flit width and arbiter state type shared by the injection arbiter slice
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
package noc_local_inject_arbiter_pkg;
  localparam int FLIT_W = `Noc_Data_Width;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
endpackage

// File: rtl/noc_rr_picker.sv
// noc_rr_picker: combinational round-robin select, searching from ptr+1 with wrap
module noc_rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] onehot,
  output logic [SRC_W-1:0]   index,
  output logic               any
);
  always_comb begin
    onehot = '0;
    index = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!any && req[(int'(ptr) + k) % NUM_SRC]) begin
        any = 1'b1;
        index = SRC_W'((int'(ptr) + k) % NUM_SRC);
        onehot[(int'(ptr) + k) % NUM_SRC] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_local_inject_arbiter.sv
// noc_local_inject_arbiter: packet-locked round-robin sharing of one router local injection port,
// with a one-entry output register, forwarded-packet counter and framing-error pulse
module noc_local_inject_arbiter
  import noc_local_inject_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*FLIT_W-1:0] src_flit,
  input  logic [NUM_SRC-1:0]        src_is_header,
  input  logic [NUM_SRC-1:0]        src_is_tail,
  output logic                      sender_valid,
  input  logic                      sender_ready,
  output logic [FLIT_W-1:0]         sender_flit,
  output logic                      sender_is_header,
  output logic                      sender_is_tail,
  output logic [SRC_W-1:0]          grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          pkt_count,
  output logic                      proto_err
);
  arb_state_e state, state_nx;
  logic [SRC_W-1:0] rr_ptr, hdr_idx, bad_idx, sel;
  logic [NUM_SRC-1:0] hdr_oh, bad_oh;
  logic hdr_any, bad_any, can_load, xfer, fwd, drop, sel_hdr, sel_tail;
  logic [FLIT_W-1:0] sel_flit;
  noc_rr_picker #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_hdr_pick (
    .req(src_valid & src_is_header), .ptr(rr_ptr), .onehot(hdr_oh), .index(hdr_idx), .any(hdr_any)
  );
  // pointer parked on the last source makes the search start at 0: lowest-index drain
  noc_rr_picker #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_bad_pick (
    .req(src_valid & ~src_is_header), .ptr(SRC_W'(NUM_SRC-1)), .onehot(bad_oh), .index(bad_idx), .any(bad_any)
  );
  assign can_load = !sender_valid || sender_ready;
  assign sel = (state == LOCKED) ? grant_id : hdr_any ? hdr_idx : bad_idx;
  assign sel_flit = src_flit[int'(sel)*FLIT_W +: FLIT_W];
  assign sel_hdr = src_is_header[sel];
  assign sel_tail = src_is_tail[sel];
  assign xfer = src_valid[sel] && src_ready[sel];
  assign fwd = xfer && (state == LOCKED || hdr_any);
  assign drop = state == IDLE && !hdr_any && bad_any && can_load;
  always_ff @(posedge noc_clk or negedge noc_rst_n)
    if (!noc_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (fwd && state == IDLE && !sel_tail) ? LOCKED :
               (fwd && state == LOCKED && sel_tail) ? IDLE : state;
  always_comb begin
    src_ready = '0;
    if (noc_rst_n && can_load)
      src_ready = (state == LOCKED) ? NUM_SRC'(1) << grant_id : hdr_any ? hdr_oh : bad_oh;
    busy = state == LOCKED;
  end
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      sender_valid <= 1'b0;
      sender_flit <= '0;
      sender_is_header <= 1'b0;
      sender_is_tail <= 1'b0;
      rr_ptr <= SRC_W'(NUM_SRC-1);
      grant_id <= '0;
      pkt_count <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= drop || (fwd && state == LOCKED && sel_hdr);
      if (fwd) begin
        sender_valid <= 1'b1;
        sender_flit <= sel_flit;
        sender_is_header <= sel_hdr;
        sender_is_tail <= sel_tail;
      end else if (sender_ready) begin
        sender_valid <= 1'b0;
      end
      if (fwd && state == IDLE) grant_id <= sel;
      if (fwd && sel_tail) begin
        rr_ptr <= sel;
        pkt_count <= pkt_count + CNT_W'(1);
      end
    end
  end
endmodule
